nlc_coeff_sched: RTL and testbench
==================================

Name: nlc_coeff_sched

Overview:
Configuration scheduler for the 4-section, 10th-order, single-channel ADC nonlinearity-correction engine. Holds a shadow bank and an active bank of all 44 polynomial coefficients, 4 means, 4 reciprocal stdevs and section_limit. A host writes the shadow bank over a valid/ready port. On commit, the block stops new samples entering the engine, waits for in-flight samples to drain, then copies shadow to active in one cycle, so no sample is ever corrected with a mix of old and new coefficients.

Parameters:
MAX_INFLIGHT, 64, max samples in engine pipeline; outstanding counter width = clog2(MAX_INFLIGHT+1)
DRAIN_TIMEOUT, 1024, cycles allowed in DRAIN before forced swap
DROP_CNT_W, 16, width of saturating dropped-sample counter

Ports:
clk  in  1  system clock
GlobalReset  in  1  asynchronous, active-low reset
cfg_wr_valid  in  1  shadow write request
cfg_wr_ready  out  1  shadow write accepted when valid&ready
cfg_wr_addr  in  6  shadow address (map below)
cfg_wr_data  in  32  write data, ufix32; addr 52 uses [19:0]
cfg_commit  in  1  single-cycle request to swap shadow->active
cfg_busy  out  1  high from commit accept until swap complete
cfg_swap_done  out  1  one-cycle pulse on the cycle after active bank updates
cfg_err  out  1  sticky: bad address, commit while busy, or counter underflow
cfg_err_clr  in  1  clears cfg_err and timeout_flag
srdyi  in  1  sample strobe from ADC
srdyi_eng  out  1  gated sample strobe to engine
srdyo_eng  in  1  output strobe from engine
drop_cnt  out  DROP_CNT_W  samples blocked during DRAIN/SWAP, saturating
timeout_flag  out  1  sticky: swap was forced by DRAIN_TIMEOUT
coeff_bus  out  1408  active coefficients; slice [(s-1)*11+k]*32 +: 32 = coeff_s_k
mean_bus  out  128  active means; slice (s-1)*32 +: 32 = mean_s
stdev_bus  out  128  active stdevs; slice (s-1)*32 +: 32 = stdev_s
section_limit  out  20  active section limit

Behaviour:
- Address map: 0..43 coeff_s_k at (s-1)*11+k (s=1..4, k=0..10); 44..47 mean_1..4; 48..51 stdev_1..4; 52 section_limit; 53..63 invalid.
- Writes to an invalid address are accepted, discarded, and set cfg_err.
- Reset: all shadow/active registers 0, state IDLE, cfg_wr_ready=1, cfg_busy=0, cfg_swap_done=0, cfg_err=0, timeout_flag=0, drop_cnt=0, outstanding=0, srdyi_eng=0.
- srdyi_eng = srdyi & (state==IDLE). This path is combinational, zero latency.
- outstanding counter: +1 on srdyi_eng, -1 on srdyo_eng; both in the same cycle leaves it unchanged.
- srdyo_eng while outstanding==0: hold at 0 and set cfg_err.
- Increment beyond MAX_INFLIGHT saturates.
- FSM states: IDLE, DRAIN, SWAP.
- IDLE: cfg_wr_ready=1. A cfg_commit goes to DRAIN next cycle.
  - A write and commit in the same cycle: the write lands in shadow first and is included in the swap.
  - srdyi in the commit cycle still passes to the engine.
- DRAIN: cfg_wr_ready=0, cfg_busy=1, and a timer counts cycles.
  - Go to SWAP when outstanding==0, or when timer==DRAIN_TIMEOUT-1 (also set timeout_flag).
  - Each srdyi while in DRAIN or SWAP increments drop_cnt, saturating at all-ones.
- SWAP (1 cycle): copy all of shadow to active; next cycle state=IDLE and cfg_swap_done=1 for one cycle.
  - cfg_busy stays high through SWAP and deasserts with the return to IDLE.
- cfg_commit while not IDLE: ignored and sets cfg_err.
- Shadow contents persist after a swap, so partial rewrites followed by a commit are legal.
- cfg_err_clr has priority below a same-cycle new error: the error sets.
- Reset asserted mid-DRAIN: returns to IDLE, active bank zeroed, and the pending commit is lost.

Optional Feature:
NLC_CFG_READBACK_EN: adds ports cfg_rd_addr (in 6), cfg_rd_sel (in 1; 0=shadow, 1=active) and cfg_rd_data (out 32).
- cfg_rd_data is registered, 1-cycle latency, zero-extended for addr 52.
- Invalid addresses read as 0.
- Without the macro these ports and their mux are absent. No other behaviour changes.

Test Plan:
- Reset, then write addr 0 = 0x00010000 and addr 52 = 0x00400, commit with srdyi idle -> DRAIN for 1 cycle, SWAP, cfg_swap_done pulse on the 3rd cycle after commit; coeff_bus[31:0]=0x00010000, section_limit=0x00400.
- Issue 5 srdyi, then commit before any srdyo_eng; return 5 srdyo_eng one per cycle starting 10 cycles later -> swap occurs the cycle after the 5th srdyo_eng; srdyi pulses during DRAIN give srdyi_eng=0 and drop_cnt increments by each.
- Commit with 3 outstanding and no srdyo_eng, DRAIN_TIMEOUT=16 -> forced swap after 16 DRAIN cycles, timeout_flag=1; cfg_err_clr clears it.
- Write addr 60 -> cfg_err=1 and shadow unchanged. Commit while cfg_busy -> ignored and cfg_err stays 1. srdyo_eng with outstanding=0 -> cfg_err=1 and the counter stays 0.
- Same-cycle write of addr 44 = 0xFFFF0000 and commit -> mean_bus[31:0]=0xFFFF0000 after the swap.
- Assert GlobalReset low during DRAIN -> all outputs return to reset values asynchronously, and no cfg_swap_done pulse follows.

Source files
------------

// File: rtl/nlc_coeff_sched.sv
// nlc_coeff_sched: shadow/active NLC coefficient banks, drain-then-swap commit; optional readback under NLC_CFG_READBACK_EN.
// Latency: commit to active update is 2+ cycles (DRAIN >= 1, SWAP 1); swap_done the cycle after; readback 1 cycle.
// Backpressure: cfg_wr_ready low and srdyi blocked (counted in drop_cnt) while DRAIN/SWAP.
module nlc_coeff_sched #(
    parameter int MAX_INFLIGHT  = 64,
    parameter int DRAIN_TIMEOUT = 1024,
    parameter int DROP_CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  GlobalReset,
    input  logic                  cfg_wr_valid,
    output logic                  cfg_wr_ready,
    input  logic [5:0]            cfg_wr_addr,
    input  logic [31:0]           cfg_wr_data,
    input  logic                  cfg_commit,
    output logic                  cfg_busy,
    output logic                  cfg_swap_done,
    output logic                  cfg_err,
    input  logic                  cfg_err_clr,
    input  logic                  srdyi,
    output logic                  srdyi_eng,
    input  logic                  srdyo_eng,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic                  timeout_flag,
    output logic [1407:0]         coeff_bus,
    output logic [127:0]          mean_bus,
    output logic [127:0]          stdev_bus,
    output logic [19:0]           section_limit
`ifdef NLC_CFG_READBACK_EN
    ,
    input  logic [5:0]            cfg_rd_addr,
    input  logic                  cfg_rd_sel,
    output logic [31:0]           cfg_rd_data
`endif
);
    localparam int NWORD = 52;
    localparam int OUT_W = $clog2(MAX_INFLIGHT + 1);
    localparam int TMR_W = $clog2(DRAIN_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, SWAP} state_t;

    state_t                state_q, state_d;
    logic [31:0]           shd_q [NWORD];
    logic [31:0]           act_q [NWORD];
    logic [19:0]           shd_lim_q, act_lim_q;
    logic [OUT_W-1:0]      out_q, out_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;
    logic                  err_q, err_d, tmo_q, tmo_d, done_q;
    logic                  idle, wr_fire, bad_addr, bad_commit, underflow, forced;

    assign idle          = (state_q == IDLE);
    assign wr_fire       = cfg_wr_valid && idle;
    assign srdyi_eng     = srdyi && idle;
    assign cfg_wr_ready  = idle;
    assign cfg_busy      = !idle;
    assign cfg_swap_done = done_q;
    assign cfg_err       = err_q;
    assign timeout_flag  = tmo_q;
    assign drop_cnt      = drop_q;
    assign section_limit = act_lim_q;

    always_comb begin
        bad_addr   = wr_fire && (cfg_wr_addr > 6'd52);
        bad_commit = cfg_commit && !idle;
        underflow  = srdyo_eng && (out_q == '0);

        out_d = out_q;
        case ({srdyi_eng, srdyo_eng})
            2'b10:   if (out_q != OUT_W'(MAX_INFLIGHT)) out_d = out_q + OUT_W'(1);
            2'b01:   if (out_q != '0) out_d = out_q - OUT_W'(1);
            default: out_d = out_q;
        endcase

        // Drain exit looks at the post-update count so the swap follows the last return directly.
        state_d = state_q;
        forced  = 1'b0;
        case (state_q)
            IDLE:    if (cfg_commit) state_d = DRAIN;
            DRAIN: begin
                if (out_d == '0) begin
                    state_d = SWAP;
                end else if (tmr_q == TMR_W'(DRAIN_TIMEOUT - 1)) begin
                    state_d = SWAP;
                    forced  = 1'b1;
                end
            end
            SWAP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        tmr_d  = (state_q == DRAIN) ? tmr_q + TMR_W'(1) : '0;
        drop_d = drop_q;
        if (srdyi && !idle && (drop_q != '1)) drop_d = drop_q + DROP_CNT_W'(1);

        err_d = err_q;
        if (bad_addr || bad_commit || underflow) err_d = 1'b1;
        else if (cfg_err_clr)                     err_d = 1'b0;
        tmo_d = tmo_q;
        if (forced)           tmo_d = 1'b1;
        else if (cfg_err_clr) tmo_d = 1'b0;
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            state_q <= IDLE;
            out_q   <= '0;
            tmr_q   <= '0;
            drop_q  <= '0;
            err_q   <= 1'b0;
            tmo_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            tmr_q   <= tmr_d;
            drop_q  <= drop_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            done_q  <= (state_q == SWAP);
        end
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            for (int i = 0; i < NWORD; i++) shd_q[i] <= '0;
            shd_lim_q <= '0;
        end else if (wr_fire) begin
            if (cfg_wr_addr < 6'd52)       shd_q[cfg_wr_addr] <= cfg_wr_data;
            else if (cfg_wr_addr == 6'd52) shd_lim_q <= cfg_wr_data[19:0];
        end
    end

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            for (int i = 0; i < NWORD; i++) act_q[i] <= '0;
            act_lim_q <= '0;
        end else if (state_q == SWAP) begin
            act_q     <= shd_q;
            act_lim_q <= shd_lim_q;
        end
    end

    for (genvar i = 0; i < 44; i++) begin : g_coeff
        assign coeff_bus[i*32 +: 32] = act_q[i];
    end
    for (genvar i = 0; i < 4; i++) begin : g_sect
        assign mean_bus[i*32 +: 32]  = act_q[44 + i];
        assign stdev_bus[i*32 +: 32] = act_q[48 + i];
    end

`ifdef NLC_CFG_READBACK_EN
    logic [31:0] rd_q;
    assign cfg_rd_data = rd_q;
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            rd_q <= '0;
        end else if (cfg_rd_addr < 6'd52) begin
            rd_q <= cfg_rd_sel ? act_q[cfg_rd_addr] : shd_q[cfg_rd_addr];
        end else if (cfg_rd_addr == 6'd52) begin
            rd_q <= {12'b0, cfg_rd_sel ? act_lim_q : shd_lim_q};
        end else begin
            rd_q <= '0;
        end
    end
`endif
endmodule

// File: tb/tb_nlc_coeff_sched.sv
// Bench for nlc_coeff_sched: directed scenarios plus randomized write/commit rounds against a bank-level model.
module tb_nlc_coeff_sched;
    logic          clk = 1'b0;
    logic          GlobalReset;
    logic          cfg_wr_valid, cfg_wr_ready, cfg_commit, cfg_busy, cfg_swap_done;
    logic          cfg_err, cfg_err_clr, srdyi, srdyi_eng, srdyo_eng, timeout_flag;
    logic [5:0]    cfg_wr_addr;
    logic [31:0]   cfg_wr_data;
    logic [15:0]   drop_cnt;
    logic [1407:0] coeff_bus;
    logic [127:0]  mean_bus, stdev_bus;
    logic [19:0]   section_limit;

    nlc_coeff_sched #(.MAX_INFLIGHT(64), .DRAIN_TIMEOUT(16), .DROP_CNT_W(16)) dut (
        .clk(clk), .GlobalReset(GlobalReset),
        .cfg_wr_valid(cfg_wr_valid), .cfg_wr_ready(cfg_wr_ready),
        .cfg_wr_addr(cfg_wr_addr), .cfg_wr_data(cfg_wr_data),
        .cfg_commit(cfg_commit), .cfg_busy(cfg_busy), .cfg_swap_done(cfg_swap_done),
        .cfg_err(cfg_err), .cfg_err_clr(cfg_err_clr),
        .srdyi(srdyi), .srdyi_eng(srdyi_eng), .srdyo_eng(srdyo_eng),
        .drop_cnt(drop_cnt), .timeout_flag(timeout_flag),
        .coeff_bus(coeff_bus), .mean_bus(mean_bus), .stdev_bus(stdev_bus),
        .section_limit(section_limit)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Bank model: 53 words in address-map order, word 52 holds the 20-bit limit zero-extended.
    logic [31:0] m_shd [53];
    logic [31:0] m_act [53];
    int          m_out;
    int          m_drop;
    logic        m_err;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        for (int i = 0; i < 53; i++) begin
            m_shd[i] = '0;
            m_act[i] = '0;
        end
        m_out  = 0;
        m_drop = 0;
        m_err  = 1'b0;
    endtask

    function automatic logic [31:0] dut_word(input int a);
        if (a < 44)      return coeff_bus[a*32 +: 32];
        else if (a < 48) return mean_bus[(a-44)*32 +: 32];
        else if (a < 52) return stdev_bus[(a-48)*32 +: 32];
        else             return {12'b0, section_limit};
    endfunction

    task automatic do_write(input int a, input logic [31:0] d);
        cfg_wr_valid = 1'b1;
        cfg_wr_addr  = 6'(a);
        cfg_wr_data  = d;
        tick();
        cfg_wr_valid = 1'b0;
        if (a < 52)       m_shd[a] = d;
        else if (a == 52) m_shd[a] = {12'b0, d[19:0]};
        else              m_err = 1'b1;
    endtask

    task automatic do_commit;
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        m_act = m_shd;
    endtask

    task automatic pulse_srdyi(input int n);
        for (int i = 0; i < n; i++) begin
            srdyi = 1'b1;
            tick();
            srdyi = 1'b0;
            m_out++;
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!ok) begin
                if (cfg_swap_done === 1'b1) ok = 1'b1;
                else tick();
            end
        end
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if (cfg_wr_ready !== 1'b1 || cfg_busy !== 1'b0 || cfg_swap_done !== 1'b0 ||
            cfg_err !== 1'b0 || timeout_flag !== 1'b0 || srdyi_eng !== 1'b0)
            begin errors++; $display("FAIL reset_ctrl: rdy=%b busy=%b done=%b err=%b tmo=%b eng=%b, required 1 0 0 0 0 0",
                cfg_wr_ready, cfg_busy, cfg_swap_done, cfg_err, timeout_flag, srdyi_eng); end
        checks++;
        if (drop_cnt !== 16'd0 || coeff_bus !== '0 || mean_bus !== '0 || stdev_bus !== '0 || section_limit !== 20'd0)
            begin errors++; $display("FAIL reset_data: drop=%0d limit=%h or banks nonzero, required all 0", drop_cnt, section_limit); end
        @(posedge clk);
        #1;
        GlobalReset = 1'b1;
    endtask

    task automatic test_basic_commit;
        do_write(0, 32'h0001_0000);
        do_write(52, 32'h0000_0400);
        do_commit();
        checks++;
        if (cfg_busy !== 1'b1 || cfg_wr_ready !== 1'b0 || cfg_swap_done !== 1'b0)
            begin errors++; $display("FAIL basic_drain: busy=%b rdy=%b done=%b, required 1 0 0", cfg_busy, cfg_wr_ready, cfg_swap_done); end
        tick();
        checks++;
        if (cfg_busy !== 1'b1 || cfg_swap_done !== 1'b0 || coeff_bus[31:0] !== 32'h0)
            begin errors++; $display("FAIL basic_swap: busy=%b done=%b c0=%h, required 1 0 0", cfg_busy, cfg_swap_done, coeff_bus[31:0]); end
        tick();
        checks++;
        if (cfg_swap_done !== 1'b1 || cfg_busy !== 1'b0 || cfg_wr_ready !== 1'b1)
            begin errors++; $display("FAIL basic_done: done=%b busy=%b rdy=%b, required 1 0 1", cfg_swap_done, cfg_busy, cfg_wr_ready); end
        checks++;
        if (coeff_bus[31:0] !== 32'h0001_0000)
            begin errors++; $display("FAIL basic_coeff0: got %h required 00010000", coeff_bus[31:0]); end
        checks++;
        if (section_limit !== 20'h00400)
            begin errors++; $display("FAIL basic_limit: got %h required 00400", section_limit); end
        tick();
        checks++;
        if (cfg_swap_done !== 1'b0)
            begin errors++; $display("FAIL basic_pulse_width: done=%b required 0", cfg_swap_done); end
    endtask

    task automatic test_drain;
        logic [31:0] d1;
        d1 = $urandom;
        do_write(1, d1);
        for (int i = 0; i < 5; i++) begin
            srdyi = 1'b1;
            #1;
            checks++;
            if (srdyi_eng !== 1'b1)
                begin errors++; $display("FAIL drain_idle_pass[%0d]: eng=%b required 1", i, srdyi_eng); end
            tick();
            srdyi = 1'b0;
            m_out++;
        end
        do_commit();
        for (int i = 0; i < 9; i++) begin
            if (i % 3 == 2) begin
                srdyi = 1'b1;
                #1;
                checks++;
                if (srdyi_eng !== 1'b0)
                    begin errors++; $display("FAIL drain_block[%0d]: eng=%b required 0", i, srdyi_eng); end
                m_drop++;
            end
            tick();
            srdyi = 1'b0;
        end
        for (int i = 0; i < 5; i++) begin
            srdyo_eng = 1'b1;
            tick();
            srdyo_eng = 1'b0;
            m_out--;
            if (i < 4) begin
                checks++;
                if (cfg_busy !== 1'b1 || cfg_swap_done !== 1'b0)
                    begin errors++; $display("FAIL drain_wait[%0d]: busy=%b done=%b, required 1 0", i, cfg_busy, cfg_swap_done); end
            end
        end
        checks++;
        if (cfg_busy !== 1'b1 || cfg_swap_done !== 1'b0 || dut_word(1) !== 32'h0)
            begin errors++; $display("FAIL drain_swap_cycle: busy=%b done=%b w1=%h, required 1 0 0", cfg_busy, cfg_swap_done, dut_word(1)); end
        srdyi = 1'b1;
        #1;
        checks++;
        if (srdyi_eng !== 1'b0)
            begin errors++; $display("FAIL swap_block: eng=%b required 0", srdyi_eng); end
        m_drop++;
        tick();
        srdyi = 1'b0;
        checks++;
        if (cfg_swap_done !== 1'b1 || dut_word(1) !== m_act[1])
            begin errors++; $display("FAIL drain_done: done=%b w1=%h, required 1 %h", cfg_swap_done, dut_word(1), m_act[1]); end
        checks++;
        if (drop_cnt !== 16'(m_drop))
            begin errors++; $display("FAIL drain_drops: got %0d required %0d", drop_cnt, m_drop); end
    endtask

    task automatic test_timeout;
        pulse_srdyi(3);
        do_commit();
        for (int i = 0; i < 15; i++) tick();
        checks++;
        if (timeout_flag !== 1'b0 || cfg_busy !== 1'b1)
            begin errors++; $display("FAIL tmo_early: tmo=%b busy=%b, required 0 1", timeout_flag, cfg_busy); end
        tick();
        checks++;
        if (timeout_flag !== 1'b1 || cfg_busy !== 1'b1 || cfg_swap_done !== 1'b0)
            begin errors++; $display("FAIL tmo_swap: tmo=%b busy=%b done=%b, required 1 1 0", timeout_flag, cfg_busy, cfg_swap_done); end
        tick();
        checks++;
        if (cfg_swap_done !== 1'b1 || cfg_busy !== 1'b0)
            begin errors++; $display("FAIL tmo_done: done=%b busy=%b, required 1 0", cfg_swap_done, cfg_busy); end
        for (int i = 0; i < 3; i++) begin
            srdyo_eng = 1'b1;
            tick();
            srdyo_eng = 1'b0;
            m_out--;
        end
        checks++;
        if (cfg_err !== m_err)
            begin errors++; $display("FAIL tmo_err: got %b required %b", cfg_err, m_err); end
        cfg_err_clr = 1'b1;
        tick();
        cfg_err_clr = 1'b0;
        checks++;
        if (timeout_flag !== 1'b0)
            begin errors++; $display("FAIL tmo_clear: tmo=%b required 0", timeout_flag); end
    endtask

    task automatic test_errors;
        do_write(60, 32'hDEAD_BEEF);
        checks++;
        if (cfg_err !== 1'b1)
            begin errors++; $display("FAIL err_bad_addr: got %b required 1", cfg_err); end
        cfg_err_clr = 1'b1;
        tick();
        cfg_err_clr = 1'b0;
        checks++;
        if (cfg_err !== 1'b0)
            begin errors++; $display("FAIL err_clear: got %b required 0", cfg_err); end
        do_commit();
        cfg_commit = 1'b1;
        tick();
        cfg_commit = 1'b0;
        checks++;
        if (cfg_err !== 1'b1)
            begin errors++; $display("FAIL err_busy_commit: got %b required 1", cfg_err); end
        tick();
        checks++;
        if (cfg_swap_done !== 1'b1)
            begin errors++; $display("FAIL err_swap_done: got %b required 1", cfg_swap_done); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (cfg_swap_done !== 1'b0 || cfg_busy !== 1'b0)
                begin errors++; $display("FAIL err_no_second_swap[%0d]: done=%b busy=%b, required 0 0", i, cfg_swap_done, cfg_busy); end
        end
        for (int a = 0; a < 53; a++) begin
            checks++;
            if (dut_word(a) !== m_act[a])
                begin errors++; $display("FAIL err_bank[%0d]: got %h required %h", a, dut_word(a), m_act[a]); end
        end
        cfg_err_clr = 1'b1;
        srdyo_eng   = 1'b1;
        tick();
        cfg_err_clr = 1'b0;
        srdyo_eng   = 1'b0;
        checks++;
        if (cfg_err !== 1'b1)
            begin errors++; $display("FAIL err_underflow_over_clr: got %b required 1", cfg_err); end
        cfg_err_clr = 1'b1;
        tick();
        cfg_err_clr = 1'b0;
        m_err = 1'b0;
        do_commit();
        tick();
        tick();
        checks++;
        if (cfg_swap_done !== 1'b1 || timeout_flag !== 1'b0 || cfg_err !== 1'b0)
            begin errors++; $display("FAIL err_counter_held: done=%b tmo=%b err=%b, required 1 0 0", cfg_swap_done, timeout_flag, cfg_err); end
    endtask

    task automatic test_same_cycle;
        bit ok;
        cfg_wr_valid = 1'b1;
        cfg_wr_addr  = 6'd44;
        cfg_wr_data  = 32'hFFFF_0000;
        cfg_commit   = 1'b1;
        srdyi        = 1'b1;
        #1;
        checks++;
        if (srdyi_eng !== 1'b1)
            begin errors++; $display("FAIL same_commit_pass: eng=%b required 1", srdyi_eng); end
        tick();
        cfg_wr_valid = 1'b0;
        cfg_commit   = 1'b0;
        srdyi        = 1'b0;
        m_shd[44] = 32'hFFFF_0000;
        m_act = m_shd;
        m_out++;
        tick();
        tick();
        srdyo_eng = 1'b1;
        tick();
        srdyo_eng = 1'b0;
        m_out--;
        wait_done(ok);
        checks++;
        if (!ok)
            begin errors++; $display("FAIL same_done_timeout: no swap_done within 40 cycles, required a pulse"); end
        checks++;
        if (mean_bus[31:0] !== 32'hFFFF_0000)
            begin errors++; $display("FAIL same_mean1: got %h required FFFF0000", mean_bus[31:0]); end
    endtask

    task automatic test_random;
        bit ok;
        int nw, n, dl, a;
        for (int r = 0; r < 4; r++) begin
            cfg_err_clr = 1'b1;
            tick();
            cfg_err_clr = 1'b0;
            m_err = 1'b0;
            nw = $urandom_range(1, 8);
            for (int w = 0; w < nw; w++) begin
                a = $urandom_range(0, 63);
                do_write(a, $urandom);
            end
            checks++;
            if (cfg_err !== m_err)
                begin errors++; $display("FAIL rand_err[%0d]: got %b required %b", r, cfg_err, m_err); end
            n = $urandom_range(0, 3);
            pulse_srdyi(n);
            do_commit();
            if (n > 0) begin
                dl = $urandom_range(0, 5);
                for (int i = 0; i < dl; i++) tick();
                for (int i = 0; i < n; i++) begin
                    srdyo_eng = 1'b1;
                    tick();
                    srdyo_eng = 1'b0;
                    m_out--;
                end
            end
            wait_done(ok);
            checks++;
            if (!ok || timeout_flag !== 1'b0)
                begin errors++; $display("FAIL rand_done[%0d]: seen=%b tmo=%b, required 1 0", r, ok, timeout_flag); end
            for (int k = 0; k < 53; k++) begin
                checks++;
                if (dut_word(k) !== m_act[k])
                    begin errors++; $display("FAIL rand_bank[%0d][%0d]: got %h required %h", r, k, dut_word(k), m_act[k]); end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid_drain;
        int seen;
        pulse_srdyi(2);
        do_write(3, $urandom | 32'h1);
        do_commit();
        tick();
        tick();
        #3;
        GlobalReset = 1'b0;
        #1;
        model_reset();
        checks++;
        if (cfg_busy !== 1'b0 || cfg_wr_ready !== 1'b1 || cfg_swap_done !== 1'b0 ||
            cfg_err !== 1'b0 || timeout_flag !== 1'b0 || srdyi_eng !== 1'b0)
            begin errors++; $display("FAIL rst_mid_ctrl: busy=%b rdy=%b done=%b err=%b tmo=%b eng=%b, required 0 1 0 0 0 0",
                cfg_busy, cfg_wr_ready, cfg_swap_done, cfg_err, timeout_flag, srdyi_eng); end
        checks++;
        if (drop_cnt !== 16'(m_drop) || coeff_bus !== '0 || mean_bus !== '0 || stdev_bus !== '0 || section_limit !== 20'd0)
            begin errors++; $display("FAIL rst_mid_data: drop=%0d limit=%h or banks nonzero, required all 0", drop_cnt, section_limit); end
        tick();
        tick();
        GlobalReset = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (cfg_swap_done === 1'b1) seen++;
        end
        checks++;
        if (seen != 0 || cfg_busy !== 1'b0)
            begin errors++; $display("FAIL rst_mid_lost_commit: pulses=%0d busy=%b, required 0 0", seen, cfg_busy); end
        do_commit();
        tick();
        tick();
        checks++;
        if (cfg_swap_done !== 1'b1 || dut_word(3) !== m_act[3])
            begin errors++; $display("FAIL rst_mid_recommit: done=%b w3=%h, required 1 %h", cfg_swap_done, dut_word(3), m_act[3]); end
    endtask

    initial begin
        GlobalReset  = 1'b0;
        cfg_wr_valid = 1'b0;
        cfg_wr_addr  = '0;
        cfg_wr_data  = '0;
        cfg_commit   = 1'b0;
        cfg_err_clr  = 1'b0;
        srdyi        = 1'b0;
        srdyo_eng    = 1'b0;
        model_reset();
        test_reset();
        test_basic_commit();
        test_drain();
        test_timeout();
        test_errors();
        test_same_cycle();
        test_random();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
